// File: rtl/serial_sum_pkg.sv
// -----------------------------------------------------------------------------
// serial_sum_pkg
// Shared types and helpers for the bit-serial sum receiver.
//   state_e      : frame state (IDLE, SHIFT, DONE)
//   count_width(): width of the bit counter for a given frame width
// -----------------------------------------------------------------------------
package serial_sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no bits received in the current frame
    SHIFT = 2'd1,  // frame partially received
    DONE  = 2'd2   // frame just completed, waiting for the next step or clear
  } state_e;

  // Counter must hold 0..width, so it needs $clog2(width+1) bits.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Synchronizes one asynchronous board-level input into the clk domain and
// produces a single-cycle pulse on its rising edge.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset (clears every flop)
//   async_i  : raw asynchronous input
//   level_o  : synchronized level (output of the last synchronizer stage)
//   rise_o   : one-cycle pulse when level_o goes 0 -> 1
// A button held high produces exactly one rise_o pulse.
// -----------------------------------------------------------------------------
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign level_o = chain_q[SYNC_STAGES-1];
  // Combinational edge so the pulse is live in the cycle the level first
  // reads high; the consuming logic registers it on the following edge.
  assign rise_o  = level_o & ~prev_q;

endmodule

// File: rtl/serial_sum_rx.sv
// -----------------------------------------------------------------------------
// serial_sum_rx
// Reassembles the serial output of the pushbutton adder lab into a parallel
// WIDTH-bit sum plus final carry. One bit is taken per press of pb_step,
// LSB first; pb_clear aborts the frame and clears the outputs.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   pb_step  : raw pushbutton, each press delivers one bit
//   pb_clear : raw pushbutton, aborts the frame and clears outputs
//   sum_bit  : serial sum bit, quasi-static while pb_step is pressed
//   cout_in  : adder carry out, captured with the last bit of a frame
//   result   : last completed sum, bit 0 = first bit received
//   carry    : cout_in captured with the last bit of the last frame
//   count    : bits received in the current frame
//   busy     : high while a frame is partially received
//   done     : one-cycle pulse in the cycle after a frame completes
// -----------------------------------------------------------------------------
module serial_sum_rx
  import serial_sum_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pb_step,
  input  logic                          pb_clear,
  input  logic                          sum_bit,
  input  logic                          cout_in,
  output logic [WIDTH-1:0]              result,
  output logic                          carry,
  output logic [count_width(WIDTH)-1:0] count,
  output logic                          busy,
  output logic                          done
);

  localparam int             CW       = count_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Input synchronization. All four inputs get the same depth so the data
  // levels line up with the step edge they belong to.
  // ---------------------------------------------------------------------------
  logic step, clear, sum_s, cout_s;
  logic step_lvl, clear_lvl, sum_rise, cout_rise;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
    .clk(clk), .rst_n(rst_n), .async_i(pb_step),  .level_o(step_lvl),  .rise_o(step)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (
    .clk(clk), .rst_n(rst_n), .async_i(pb_clear), .level_o(clear_lvl), .rise_o(clear)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sum (
    .clk(clk), .rst_n(rst_n), .async_i(sum_bit),  .level_o(sum_s),     .rise_o(sum_rise)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cout (
    .clk(clk), .rst_n(rst_n), .async_i(cout_in),  .level_o(cout_s),    .rise_o(cout_rise)
  );

  // Buttons are used only as edges and data only as levels.
  logic sync_unused;
  assign sync_unused = ^{step_lvl, clear_lvl, sum_rise, cout_rise};

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_e           state_q,  state_d;
  logic [WIDTH-1:0] sr_q,     sr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] shifted;

  // New bit enters at the top so that after WIDTH shifts the first bit
  // received has reached bit 0.
  assign shifted = {sum_s, sr_q[WIDTH-1:1]};

  // NOTE: every signal driven here gets a default first; a path that skipped
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    count_d  = count_q;
    result_d = result_q;
    carry_d  = carry_q;
    done_d   = 1'b0;

    if (clear) begin
      // Clear has priority; a coincident step is dropped.
      state_d  = IDLE;
      sr_d     = '0;
      count_d  = '0;
      result_d = '0;
      carry_d  = 1'b0;
    end else if (step) begin
      sr_d = shifted;
      if (count_q == LAST_CNT) begin
        state_d  = DONE;
        count_d  = '0;
        result_d = shifted;
        carry_d  = cout_s;
        done_d   = 1'b1;
      end else begin
        // From IDLE or DONE count_q is 0, so this starts a new frame at 1.
        state_d = SHIFT;
        count_d = count_q + CW'(1);
      end
    end
  end

  // NOTE: the shift register is plain control state, so it is reset along
  // with everything else; it is small and clear already forces it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      count_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      count_q  <= count_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign count  = count_q;
  assign busy   = (state_q == SHIFT);
  assign done   = done_q;

endmodule

// File: tb/tb_serial_sum_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_sum_rx
// Directed bench for serial_sum_rx (WIDTH = 6, SYNC_STAGES = 2). Expected
// frame results are pushed into a queue when the last bit is issued; a
// monitor pops and compares whenever done is seen. Level checks on count,
// busy, result and carry are made directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_serial_sum_rx;

  localparam int WIDTH = 6;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             pb_step;
  logic             pb_clear;
  logic             sum_bit;
  logic             cout_in;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  serial_sum_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .pb_step(pb_step), .pb_clear(pb_clear),
    .sum_bit(sum_bit), .cout_in(cout_in), .result(result), .carry(carry),
    .count(count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  // A done lasting two cycles shows up as an unexpected second pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: done=1, expected no frame (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_result", 32'(result), 32'(e.result));
        check("done_carry",  32'(carry),  32'(e.carry));
      end
    end
  end

  // One button press: data set up well ahead, button held `hold` cycles.
  // Entered and left at posedge + 1.
  task automatic press(input logic b, input logic c, input int hold);
    sum_bit = b;
    cout_in = c;
    repeat (3) @(posedge clk);
    #1 pb_step = 1'b1;
    repeat (hold) @(posedge clk);
    #1 pb_step = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic press_frame(input logic [WIDTH-1:0] bits, input logic last_cout);
    for (int i = 0; i < WIDTH; i++)
      press(bits[i], (i == WIDTH - 1) ? last_cout : 1'b0, 3);
  endtask

  initial begin
    rst_n    = 1'b0;
    pb_step  = 1'b0;
    pb_clear = 1'b0;
    sum_bit  = 1'b0;
    cout_in  = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", 32'(result), 0);
    check("rst_carry",  32'(carry),  0);
    check("rst_count",  32'(count),  0);
    check("rst_busy",   32'(busy),   0);
    check("rst_done",   32'(done),   0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // ---- full frame: bits 1,0,1,1,0,1 LSB first, carry 1 -> 6'b101101 ----
    exp_q.push_back('{result: 6'b101101, carry: 1'b1});
    press_frame(6'b101101, 1'b1);
    check("frame1_busy",   32'(busy),   0);
    check("frame1_count",  32'(count),  0);
    check("frame1_result", 32'(result), 32'(6'b101101));
    check("frame1_carry",  32'(carry),  1);

    // ---- restart from DONE: 3 bits, old result holds ----
    press(1'b1, 1'b0, 3);
    press(1'b1, 1'b0, 3);
    press(1'b1, 1'b0, 3);
    check("restart_result_hold", 32'(result), 32'(6'b101101));
    check("restart_carry_hold",  32'(carry),  1);
    check("restart_count",       32'(count),  3);
    check("restart_busy",        32'(busy),   1);
    // bits 1,1,1,0,0,0 -> 6'b000111, carry 0
    exp_q.push_back('{result: 6'b000111, carry: 1'b0});
    press(1'b0, 1'b0, 3);
    press(1'b0, 1'b0, 3);
    press(1'b0, 1'b0, 3);
    check("restart_result", 32'(result), 32'(6'b000111));
    check("restart_carry",  32'(carry),  0);

    // ---- held button: 50 cycles high is one bit ----
    press(1'b1, 1'b0, 50);
    check("held_count", 32'(count), 1);
    check("held_busy",  32'(busy),  1);

    // ---- clear vs step in the same cycle ----
    press(1'b0, 1'b0, 3);
    press(1'b1, 1'b0, 3);
    press(1'b1, 1'b0, 3);
    check("pre_clear_count", 32'(count), 4);
    sum_bit = 1'b1;
    cout_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pb_clear = 1'b1;
    pb_step  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pb_clear = 1'b0;
    pb_step  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("clear_count",  32'(count),  0);
    check("clear_result", 32'(result), 0);
    check("clear_carry",  32'(carry),  0);
    check("clear_busy",   32'(busy),   0);

    // ---- reset mid-frame after a completed frame ----
    exp_q.push_back('{result: 6'b101101, carry: 1'b1});
    press_frame(6'b101101, 1'b1);
    press(1'b1, 1'b0, 3);
    press(1'b0, 1'b0, 3);
    press(1'b1, 1'b0, 3);
    check("midframe_count", 32'(count), 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", 32'(result), 0);
    check("midrst_carry",  32'(carry),  0);
    check("midrst_count",  32'(count),  0);
    check("midrst_busy",   32'(busy),   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    press(1'b0, 1'b0, 3);
    check("post_rst_count", 32'(count), 1);
    check("post_rst_busy",  32'(busy),  1);

    // ---- latency: bits 0,1,0,0 so far shown below, then 1,1 -> 6'b110010 ----
    press(1'b1, 1'b0, 3);
    press(1'b0, 1'b0, 3);
    press(1'b0, 1'b0, 3);
    check("lat_pre_count", 32'(count), 4);
    // 5th bit: pb_step first sampled at edge k, count moves at edge k+2
    sum_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1 pb_step = 1'b1;
    @(posedge clk);                      // edge k
    @(negedge clk); check("lat_k_count",  32'(count), 4);
    @(posedge clk);                      // edge k+1
    @(negedge clk); check("lat_k1_count", 32'(count), 4);
    @(posedge clk);                      // edge k+2
    @(negedge clk); check("lat_k2_count", 32'(count), 5);
    @(posedge clk);
    #1 pb_step = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // 6th bit completes the frame: done visible after edge k+2, gone after k+3
    exp_q.push_back('{result: 6'b110010, carry: 1'b0});
    sum_bit = 1'b1;
    cout_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 pb_step = 1'b1;
    @(posedge clk);                      // edge k
    @(posedge clk);                      // edge k+1
    @(negedge clk); check("lat6_k1_done", 32'(done), 0);
    @(posedge clk);                      // edge k+2
    @(negedge clk);
    check("lat6_k2_done",  32'(done),  1);
    check("lat6_k2_count", 32'(count), 0);
    @(posedge clk);                      // edge k+3
    @(negedge clk); check("lat6_k3_done", 32'(done), 0);
    #1 pb_step = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("lat_result", 32'(result), 32'(6'b110010));
    check("lat_busy",   32'(busy),   0);

    // every expected frame must have been seen
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
